// File: rtl/sys_rx_cmd_ctrl_if.sv
// sys_rx_cmd_ctrl_if: bundles every non-clock signal of the UART receive-side
// command sequencer.
//   RX_*   : received byte and its one-cycle valid pulse
//   RF_*   : register-file write/read strobes, address, write data, read data
//   TX_*   : byte and request handed to the transmitter, transmitter busy
//   CFG_*  : live link configuration (parity enable/type, prescale)
//   Cmd_error : one-cycle protocol error pulse
// slave  = the sequencer itself, master = its surroundings.
interface sys_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] RX_P_Data;
  logic              RX_D_VLD;
  logic              RF_WrEn;
  logic              RF_RdEn;
  logic [ADDR_W-1:0] RF_Address;
  logic [DATA_W-1:0] RF_WrData;
  logic [DATA_W-1:0] RF_RdData;
  logic              RF_RdData_VLD;
  logic [DATA_W-1:0] TX_P_Data;
  logic              TX_D_VLD;
  logic              TX_Busy;
  logic              CFG_Parity_EN;
  logic              CFG_Parity_type;
  logic [5:0]        CFG_Prescale;
  logic              Cmd_error;

  modport slave (
    input  RX_P_Data, RX_D_VLD, RF_RdData, RF_RdData_VLD, TX_Busy,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_Data, TX_D_VLD,
           CFG_Parity_EN, CFG_Parity_type, CFG_Prescale, Cmd_error
  );

  modport master (
    output RX_P_Data, RX_D_VLD, RF_RdData, RF_RdData_VLD, TX_Busy,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_Data, TX_D_VLD,
           CFG_Parity_EN, CFG_Parity_type, CFG_Prescale, Cmd_error
  );
endinterface

// File: rtl/sys_rx_cmd_ctrl.sv
// sys_rx_cmd_ctrl: decodes received UART bytes into register-file write,
// register-file read (result forwarded to the transmitter) and link
// configuration commands. All outputs are registered.
//   CLK   : system clock
//   Reset : asynchronous, active-high
//   bus   : sys_rx_cmd_ctrl_if.slave (RX byte in, RF / TX / CFG / error out)
module sys_rx_cmd_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic              CLK,
  input logic              Reset,
  sys_rx_cmd_ctrl_if.slave bus
);
  // Counter only ever holds 0..TIMEOUT-1: the cycle it would reach TIMEOUT
  // is the abort cycle, after which it is cleared.
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] OP_WR    = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_RD    = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OP_CFG   = DATA_W'(8'hCC);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT, CFG_DATA
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d, tx_data_q, tx_data_d;
  logic               tx_vld_q, tx_vld_d, cmd_err_q, cmd_err_d;
  logic               par_en_q, par_en_d, par_type_q, par_type_d;
  logic [5:0]         prescale_q, prescale_d;

  logic              rx_vld, rd_vld, tx_busy, timed, expire;
  logic [DATA_W-1:0] rx_byte;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_Data;
  assign rd_vld  = bus.RF_RdData_VLD;
  assign tx_busy = bus.TX_Busy;
  assign timed   = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, CFG_DATA};
  // A byte / read-data pulse in the expiry cycle takes priority (checked first below).
  assign expire  = timed && (cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_vld) begin
        if (rx_byte == OP_WR)       state_d = WR_ADDR;
        else if (rx_byte == OP_RD)  state_d = RD_ADDR;
        else if (rx_byte == OP_CFG) state_d = CFG_DATA;
      end
      WR_ADDR:  if (rx_vld) state_d = WR_DATA; else if (expire) state_d = IDLE;
      WR_DATA:  if (rx_vld || expire) state_d = IDLE;
      RD_ADDR:  if (rx_vld) state_d = RD_WAIT; else if (expire) state_d = IDLE;
      // Transmitter already free: skip TX_WAIT and send straight away.
      RD_WAIT:  if (rd_vld) state_d = tx_busy ? TX_WAIT : IDLE;
                else if (expire) state_d = IDLE;
      TX_WAIT:  if (!tx_busy) state_d = IDLE;
      CFG_DATA: if (rx_vld || expire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Every state change clears the counter; dropped bytes in RD_WAIT do not.
    cnt_d = (timed && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
  end

  // outputs
  always_comb begin
    rf_wr_en_d = 1'b0;
    rf_rd_en_d = 1'b0;
    tx_vld_d   = 1'b0;
    cmd_err_d  = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    tx_data_d  = tx_data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    prescale_d = prescale_q;
    unique case (state_q)
      IDLE: if (rx_vld && !(rx_byte inside {OP_WR, OP_RD, OP_CFG})) cmd_err_d = 1'b1;
      WR_ADDR, RD_ADDR: begin
        if (rx_vld) begin
          rf_addr_d  = rx_byte[ADDR_W-1:0];
          rf_rd_en_d = (state_q == RD_ADDR);
        end else if (expire) cmd_err_d = 1'b1;
      end
      WR_DATA: begin
        if (rx_vld) begin
          rf_wdata_d = rx_byte;
          rf_wr_en_d = 1'b1;
        end else if (expire) cmd_err_d = 1'b1;
      end
      RD_WAIT: begin
        if (rx_vld) cmd_err_d = 1'b1;
        if (rd_vld) begin
          tx_data_d = bus.RF_RdData;
          tx_vld_d  = !tx_busy;
        end else if (expire) cmd_err_d = 1'b1;
      end
      TX_WAIT: begin
        if (rx_vld)   cmd_err_d = 1'b1;
        if (!tx_busy) tx_vld_d  = 1'b1;
      end
      CFG_DATA: begin
        if (rx_vld) begin
          if (|rx_byte[5:0]) begin
            par_en_d   = rx_byte[7];
            par_type_d = rx_byte[6];
            prescale_d = rx_byte[5:0];
          end else cmd_err_d = 1'b1;  // prescale 0 would stall the receiver
        end else if (expire) cmd_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      par_en_q   <= 1'b1;
      par_type_q <= 1'b0;
      prescale_q <= 6'd8;
    end else begin
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_en_q <= rf_rd_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      cmd_err_q  <= cmd_err_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      prescale_q <= prescale_d;
    end
  end

  assign bus.RF_WrEn         = rf_wr_en_q;
  assign bus.RF_RdEn         = rf_rd_en_q;
  assign bus.RF_Address      = rf_addr_q;
  assign bus.RF_WrData       = rf_wdata_q;
  assign bus.TX_P_Data       = tx_data_q;
  assign bus.TX_D_VLD        = tx_vld_q;
  assign bus.Cmd_error       = cmd_err_q;
  assign bus.CFG_Parity_EN   = par_en_q;
  assign bus.CFG_Parity_type = par_type_q;
  assign bus.CFG_Prescale    = prescale_q;
endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// Bench for sys_rx_cmd_ctrl: random commands against a spec-level model
// (register-file contents, config, expected pulse counts).
module tb_sys_rx_cmd_ctrl;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic Reset;
  sys_rx_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sys_rx_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int exp_wr = 0, exp_rd = 0, exp_tx = 0, exp_err = 0;
  int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
  logic [7:0] m_mem [16];    // expected register-file contents
  logic [7:0] env_mem [16];  // register file as built by DUT strobes
  logic       m_en, m_type;
  logic [5:0] m_pre;

  // Pulse counter / register-file emulation, sampled away from the edge.
  always @(negedge CLK) if (!Reset) begin
    if (bus.RF_WrEn) begin n_wr++; env_mem[bus.RF_Address] = bus.RF_WrData; end
    if (bus.RF_RdEn) n_rd++;
    if (bus.TX_D_VLD) n_tx++;
    if (bus.Cmd_error) n_err++;
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask
  task automatic send(input logic [7:0] b);
    bus.RX_P_Data = b; bus.RX_D_VLD = 1'b1; tick();
    bus.RX_D_VLD = 1'b0; bus.RX_P_Data = 8'($urandom);
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(2);
    checks++; if (bus.RF_WrEn !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b want 0", bus.RF_WrEn); end
    checks++; if (bus.RF_RdEn !== 1'b0) begin failures++; $display("FAIL rst_rden: got %b want 0", bus.RF_RdEn); end
    checks++; if (bus.RF_Address !== 4'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.RF_Address); end
    checks++; if (bus.RF_WrData !== 8'h00) begin failures++; $display("FAIL rst_wdata: got %h want 0", bus.RF_WrData); end
    checks++; if (bus.TX_P_Data !== 8'h00) begin failures++; $display("FAIL rst_txdata: got %h want 0", bus.TX_P_Data); end
    checks++; if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rst_txvld: got %b want 0", bus.TX_D_VLD); end
    checks++; if (bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", bus.Cmd_error); end
    checks++; if (bus.CFG_Parity_EN !== 1'b1) begin failures++; $display("FAIL rst_pen: got %b want 1", bus.CFG_Parity_EN); end
    checks++; if (bus.CFG_Parity_type !== 1'b0) begin failures++; $display("FAIL rst_ptype: got %b want 0", bus.CFG_Parity_type); end
    checks++; if (bus.CFG_Prescale !== 6'd8) begin failures++; $display("FAIL rst_pre: got %0d want 8", bus.CFG_Prescale); end
    #2 Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    logic [7:0] a, d;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      if (i < 16) a[3:0] = 4'(i);
      d = (i == 0) ? 8'h5A : 8'($urandom);
      if (i == 0) a = 8'h03;
      send(8'hAA); idle($urandom_range(0, 3));
      send(a);
      checks++; if (bus.RF_Address !== a[3:0]) begin failures++; $display("FAIL wr_addr_latch: got %h want %h", bus.RF_Address, a[3:0]); end
      idle($urandom_range(0, 3));
      send(d);
      checks++; if (bus.RF_WrEn !== 1'b1) begin failures++; $display("FAIL wr_en: got %b want 1", bus.RF_WrEn); end
      checks++; if (bus.RF_Address !== a[3:0]) begin failures++; $display("FAIL wr_addr: got %h want %h", bus.RF_Address, a[3:0]); end
      checks++; if (bus.RF_WrData !== d) begin failures++; $display("FAIL wr_data: got %h want %h", bus.RF_WrData, d); end
      checks++; if (bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", bus.Cmd_error); end
      m_mem[a[3:0]] = d; exp_wr++;
      tick();
      checks++; if (bus.RF_WrEn !== 1'b0) begin failures++; $display("FAIL wr_en_pulse: got %b want 0", bus.RF_WrEn); end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_read();
    logic [7:0] a;
    int d, b;
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 8'h07 : 8'($urandom);
      d = (i == 0) ? 3 : $urandom_range(0, 4);
      b = (i == 0) ? 5 : $urandom_range(0, 5);
      send(8'hBB); idle($urandom_range(0, 3));
      send(a);
      checks++; if (bus.RF_RdEn !== 1'b1) begin failures++; $display("FAIL rd_en: got %b want 1", bus.RF_RdEn); end
      checks++; if (bus.RF_Address !== a[3:0]) begin failures++; $display("FAIL rd_addr: got %h want %h", bus.RF_Address, a[3:0]); end
      exp_rd++;
      idle(d);
      for (int c = 0; c <= b; c++) begin
        bus.RF_RdData = (c == 0) ? env_mem[bus.RF_Address] : 8'($urandom);
        bus.RF_RdData_VLD = (c == 0);
        bus.TX_Busy = (c < b);
        tick();
        checks++; if (bus.TX_D_VLD !== (c == b)) begin failures++; $display("FAIL rd_txvld c=%0d: got %b want %b", c, bus.TX_D_VLD, c == b); end
      end
      checks++; if (bus.TX_P_Data !== m_mem[a[3:0]]) begin failures++; $display("FAIL rd_txdata: got %h want %h", bus.TX_P_Data, m_mem[a[3:0]]); end
      exp_tx++;
      bus.RF_RdData_VLD = 1'b0; bus.TX_Busy = 1'b0;
      tick();
      checks++; if (bus.TX_D_VLD !== 1'b0) begin failures++; $display("FAIL rd_txvld_pulse: got %b want 0", bus.TX_D_VLD); end
    end
  endtask

  task automatic test_config();
    logic [7:0] c;
    for (int i = 0; i < 10; i++) begin
      c = (i == 0) ? 8'h8F : (i == 1) ? 8'h40 : 8'($urandom);
      if (i > 1 && $urandom_range(0, 2) == 0) c[5:0] = 6'd0;
      send(8'hCC); idle($urandom_range(0, 3));
      send(c);
      if (c[5:0] != 6'd0) begin m_en = c[7]; m_type = c[6]; m_pre = c[5:0]; end
      else exp_err++;
      checks++; if (bus.Cmd_error !== (c[5:0] == 6'd0)) begin failures++; $display("FAIL cfg_err %h: got %b want %b", c, bus.Cmd_error, c[5:0] == 6'd0); end
      checks++; if ({bus.CFG_Parity_EN, bus.CFG_Parity_type, bus.CFG_Prescale} !== {m_en, m_type, m_pre})
        begin failures++; $display("FAIL cfg_val %h: got %b/%b/%0d want %b/%b/%0d", c, bus.CFG_Parity_EN, bus.CFG_Parity_type, bus.CFG_Prescale, m_en, m_type, m_pre); end
      tick();
      checks++; if (bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse: got %b want 0", bus.Cmd_error); end
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) b = 8'h11;
      else do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC);
      send(b);
      exp_err++;
      checks++; if (bus.Cmd_error !== 1'b1) begin failures++; $display("FAIL bad_op %h err: got %b want 1", b, bus.Cmd_error); end
      checks++; if ({bus.RF_WrEn, bus.RF_RdEn} !== 2'b00) begin failures++; $display("FAIL bad_op strobes: got %b want 00", {bus.RF_WrEn, bus.RF_RdEn}); end
      tick();
      checks++; if (bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL bad_op pulse: got %b want 0", bus.Cmd_error); end
    end
  endtask

  // st: 0 WR_ADDR, 1 WR_DATA, 2 RD_ADDR, 3 CFG_DATA, 4 RD_WAIT
  task automatic test_timeout();
    logic [7:0] d;
    for (int st = 0; st < 5; st++) begin
      for (int win = 0; win < 2; win++) begin
        if (win == 1 && !(st == 1 || st == 3 || st == 4)) continue;
        case (st)
          0: send(8'hAA);
          1: begin send(8'hAA); send(8'h01); end
          2: send(8'hBB);
          3: send(8'hCC);
          default: begin send(8'hBB); send(8'h01); exp_rd++; end
        endcase
        idle(TO - 1);
        checks++; if (bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL to_early st=%0d: got %b want 0", st, bus.Cmd_error); end
        if (win == 0) begin
          tick();
          exp_err++;
          checks++; if (bus.Cmd_error !== 1'b1) begin failures++; $display("FAIL to_err st=%0d: got %b want 1", st, bus.Cmd_error); end
          checks++; if ({bus.RF_WrEn, bus.RF_RdEn, bus.TX_D_VLD} !== 3'b000) begin failures++; $display("FAIL to_strobe st=%0d: got %b want 000", st, {bus.RF_WrEn, bus.RF_RdEn, bus.TX_D_VLD}); end
          tick();
          // back in IDLE: a full write must work normally
          d = 8'($urandom);
          send(8'hAA); send(8'h01); send(d);
          m_mem[1] = d; exp_wr++;
          checks++; if (bus.RF_WrEn !== 1'b1 || bus.RF_WrData !== d) begin failures++; $display("FAIL to_recover st=%0d: got %b/%h want 1/%h", st, bus.RF_WrEn, bus.RF_WrData, d); end
        end else if (st == 1) begin
          d = 8'($urandom);
          send(d);
          m_mem[1] = d; exp_wr++;
          checks++; if (bus.RF_WrEn !== 1'b1 || bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL to_win_wr: got wren=%b err=%b want 1/0", bus.RF_WrEn, bus.Cmd_error); end
        end else if (st == 3) begin
          d = {2'($urandom), 6'($urandom_range(1, 63))};
          send(d);
          m_en = d[7]; m_type = d[6]; m_pre = d[5:0];
          checks++; if (bus.Cmd_error !== 1'b0 || bus.CFG_Prescale !== m_pre) begin failures++; $display("FAIL to_win_cfg: got err=%b pre=%0d want 0/%0d", bus.Cmd_error, bus.CFG_Prescale, m_pre); end
        end else begin
          bus.RF_RdData = env_mem[bus.RF_Address]; bus.RF_RdData_VLD = 1'b1; bus.TX_Busy = 1'b0;
          tick();
          bus.RF_RdData_VLD = 1'b0;
          exp_tx++;
          checks++; if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_Data !== m_mem[1] || bus.Cmd_error !== 1'b0)
            begin failures++; $display("FAIL to_win_rd: got vld=%b data=%h err=%b want 1/%h/0", bus.TX_D_VLD, bus.TX_P_Data, bus.Cmd_error, m_mem[1]); end
        end
        tick();
      end
    end
  endtask

  task automatic test_rd_wait_drop();
    send(8'hBB); send(8'h02); exp_rd++;
    checks++; if (bus.RF_RdEn !== 1'b1) begin failures++; $display("FAIL drop_rden: got %b want 1", bus.RF_RdEn); end
    tick();
    send(8'h55); exp_err++;
    checks++; if (bus.Cmd_error !== 1'b1) begin failures++; $display("FAIL drop_rdwait_err: got %b want 1", bus.Cmd_error); end
    bus.RF_RdData = env_mem[bus.RF_Address]; bus.RF_RdData_VLD = 1'b1; bus.TX_Busy = 1'b1;
    tick();
    bus.RF_RdData_VLD = 1'b0;
    send(8'h55); exp_err++;   // lands in TX_WAIT
    checks++; if (bus.Cmd_error !== 1'b1 || bus.TX_D_VLD !== 1'b0) begin failures++; $display("FAIL drop_txwait: got err=%b vld=%b want 1/0", bus.Cmd_error, bus.TX_D_VLD); end
    bus.TX_Busy = 1'b0;
    tick(); exp_tx++;
    checks++; if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_Data !== m_mem[2]) begin failures++; $display("FAIL drop_tx: got vld=%b data=%h want 1/%h", bus.TX_D_VLD, bus.TX_P_Data, m_mem[2]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      send(8'hAA); send(a); send(d);
      m_mem[a[3:0]] = d; exp_wr++;
      checks++; if (bus.RF_WrEn !== 1'b1 || bus.RF_WrData !== d) begin failures++; $display("FAIL b2b_wr: got %b/%h want 1/%h", bus.RF_WrEn, bus.RF_WrData, d); end
      send(8'hBB); send(a); exp_rd++;
      checks++; if (bus.RF_RdEn !== 1'b1) begin failures++; $display("FAIL b2b_rden: got %b want 1", bus.RF_RdEn); end
      bus.RF_RdData = env_mem[bus.RF_Address]; bus.RF_RdData_VLD = 1'b1; bus.TX_Busy = 1'b0;
      tick();
      bus.RF_RdData_VLD = 1'b0; exp_tx++;
      checks++; if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_Data !== d) begin failures++; $display("FAIL b2b_tx: got %b/%h want 1/%h", bus.TX_D_VLD, bus.TX_P_Data, d); end
    end
    tick();
  endtask

  task automatic test_reset_midcmd();
    logic [5:0] p;
    p = 6'($urandom_range(1, 63));
    if (p == 6'd8) p = 6'd9;
    send(8'hCC); send({2'b01, p});
    checks++; if (bus.CFG_Prescale !== p || bus.CFG_Parity_EN !== 1'b0) begin failures++; $display("FAIL mid_cfg: got %0d/%b want %0d/0", bus.CFG_Prescale, bus.CFG_Parity_EN, p); end
    send(8'hAA); send(8'h05);   // now in WR_DATA
    #3 Reset = 1'b1;
    #1;
    checks++; if ({bus.RF_WrEn, bus.RF_RdEn, bus.TX_D_VLD, bus.Cmd_error} !== 4'b0000) begin failures++; $display("FAIL mid_rst_strobes: got %b want 0000", {bus.RF_WrEn, bus.RF_RdEn, bus.TX_D_VLD, bus.Cmd_error}); end
    checks++; if (bus.RF_Address !== 4'h0 || bus.RF_WrData !== 8'h00 || bus.TX_P_Data !== 8'h00) begin failures++; $display("FAIL mid_rst_data: got %h/%h/%h want 0/00/00", bus.RF_Address, bus.RF_WrData, bus.TX_P_Data); end
    checks++; if ({bus.CFG_Parity_EN, bus.CFG_Parity_type, bus.CFG_Prescale} !== {1'b1, 1'b0, 6'd8}) begin failures++; $display("FAIL mid_rst_cfg: got %b/%b/%0d want 1/0/8", bus.CFG_Parity_EN, bus.CFG_Parity_type, bus.CFG_Prescale); end
    m_en = 1'b1; m_type = 1'b0; m_pre = 6'd8;
    tick();
    #2 Reset = 1'b0;
    tick();
    send(8'hAA);
    checks++; if (bus.RF_WrEn !== 1'b0 || bus.Cmd_error !== 1'b0) begin failures++; $display("FAIL mid_fresh_op: got wren=%b err=%b want 0/0", bus.RF_WrEn, bus.Cmd_error); end
    send(8'h03); send(8'h5A);
    m_mem[3] = 8'h5A; exp_wr++;
    checks++; if (bus.RF_WrEn !== 1'b1 || bus.RF_Address !== 4'h3 || bus.RF_WrData !== 8'h5A) begin failures++; $display("FAIL mid_write: got %b/%h/%h want 1/3/5a", bus.RF_WrEn, bus.RF_Address, bus.RF_WrData); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_mem[i] = 8'h00; env_mem[i] = 8'h00; end
    m_en = 1'b1; m_type = 1'b0; m_pre = 6'd8;
    Reset = 1'b1;
    bus.RX_P_Data = 8'h00; bus.RX_D_VLD = 1'b0;
    bus.RF_RdData = 8'h00; bus.RF_RdData_VLD = 1'b0; bus.TX_Busy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_config();
    test_bad_opcode();
    test_timeout();
    test_rd_wait_drop();
    test_back_to_back();
    test_reset_midcmd();
    idle(2);
    checks++; if (n_wr !== exp_wr) begin failures++; $display("FAIL count_wr: got %0d want %0d", n_wr, exp_wr); end
    checks++; if (n_rd !== exp_rd) begin failures++; $display("FAIL count_rd: got %0d want %0d", n_rd, exp_rd); end
    checks++; if (n_tx !== exp_tx) begin failures++; $display("FAIL count_tx: got %0d want %0d", n_tx, exp_tx); end
    checks++; if (n_err !== exp_err) begin failures++; $display("FAIL count_err: got %0d want %0d", n_err, exp_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
